wb_mixer_rr: RTL and testbench

Parametrised N-channel Wishbone master mixer with a built-in round-robin arbiter and a bus-response timeout. It sits between the DMA channel engines (and the management channel) and the single shared Wishbone master port. Requests are granted one whole bus cycle (`cyc` assertion) at a time, and responses are routed only to the owning channel. A watchdog terminates a stalled access with an error.

---
 rtl/wb_mixer_rr.sv | 170 +++++++++++++++++
 tb/tb_wb_mixer_rr.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mixer_rr.sv
// wb_mixer_rr: N-channel Wishbone master mixer. A round-robin arbiter hands
// the single shared master port to one channel for a whole cyc assertion;
// responses are routed only to the owner, and a watchdog ends stalled
// accesses with an error.
//
// Handshake: a channel requests by raising cyc and keeps it high for as many
// beats as it needs; each beat is one stb cycle completed by ack, err or rty
// in the same cycle (combinational response path). Dropping cyc releases the
// bus; the next owner drives it one cycle later. The arbiter never preempts
// an owner whose cyc is high.
module wb_mixer_rr #(
    parameter int NCH = 5,
    parameter int DW  = 64,
    parameter int AW  = 32,
    parameter int TMO = 255
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [NCH-1:0]        wbs_cyc_i,
    input  logic [NCH-1:0]        wbs_stb_i,
    input  logic [NCH-1:0]        wbs_we_i,
    input  logic [NCH-1:0]        wbs_cab_i,
    input  logic [NCH*DW/8-1:0]   wbs_sel_i,
    input  logic [NCH*AW-1:0]     wbs_adr_i,
    input  logic [NCH*DW-1:0]     wbs_dat_i,
    output logic [DW-1:0]         wbs_dat_o,
    output logic [NCH-1:0]        wbs_ack_o,
    output logic [NCH-1:0]        wbs_err_o,
    output logic [NCH-1:0]        wbs_rty_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic                  wbm_cab_o,
    output logic [DW/8-1:0]       wbm_sel_o,
    output logic [AW-1:0]         wbm_adr_o,
    output logic [DW-1:0]         wbm_dat_o,
    input  logic                  wbm_ack_i,
    input  logic                  wbm_err_i,
    input  logic                  wbm_rty_i,
    input  logic [DW-1:0]         wbm_dat_i,
    output logic [NCH-1:0]        gnt_o,
    output logic                  tmo_o
);

    localparam int SW = DW / 8;
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [TW-1:0]  tcnt_q, tcnt_d;

    logic           arb_found;
    logic [PW-1:0]  arb_idx;
    logic [PW:0]    arb_j;
    logic           own_cyc;
    logic           resp;
    logic           tmo_hit;

    // State, grant, last-owner pointer and watchdog counter registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            ptr_q   <= PW'(NCH - 1);
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // Round-robin search: first requester after the last owner, wrapping; the
    // last owner itself is visited last, so it only wins when alone.
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = ptr_q;
        arb_j     = '0;
        for (int i = 1; i <= NCH; i++) begin
            arb_j = {1'b0, ptr_q} + (PW + 1)'(i);
            if (arb_j >= (PW + 1)'(NCH)) begin
                arb_j = arb_j - (PW + 1)'(NCH);
            end
            if (!arb_found && wbs_cyc_i[arb_j[PW-1:0]]) begin
                arb_found = 1'b1;
                arb_idx   = arb_j[PW-1:0];
            end
        end
    end

    assign own_cyc = |(gnt_q & wbs_cyc_i);

    // Next-state logic: grant on request, hold while owner cyc is high,
    // re-arbitrate in the release cycle, and run the watchdog counter.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d   = NCH'(1) << arb_idx;
                    ptr_d   = arb_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                if (!own_cyc) begin
                    if (arb_found) begin
                        gnt_d = NCH'(1) << arb_idx;
                        ptr_d = arb_idx;
                    end else begin
                        gnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        tcnt_d = tcnt_q;
        if ((TMO == 0) || !wbm_stb_o || resp || tmo_hit) begin
            tcnt_d = '0;
        end else if (tcnt_q != TW'(TMO)) begin
            tcnt_d = tcnt_q + TW'(1);
        end
    end

    // Outputs: AND-OR mux of the owner onto the master port, response
    // routing to the owner only, and the watchdog strike.
    always_comb begin
        wbm_cyc_o = 1'b0;
        wbm_stb_o = 1'b0;
        wbm_we_o  = 1'b0;
        wbm_cab_o = 1'b0;
        wbm_sel_o = '0;
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        for (int k = 0; k < NCH; k++) begin
            wbm_cyc_o = wbm_cyc_o | (wbs_cyc_i[k] & gnt_q[k]);
            wbm_stb_o = wbm_stb_o | (wbs_stb_i[k] & gnt_q[k]);
            wbm_we_o  = wbm_we_o  | (wbs_we_i[k]  & gnt_q[k]);
            wbm_cab_o = wbm_cab_o | (wbs_cab_i[k] & gnt_q[k]);
            wbm_sel_o = wbm_sel_o | (wbs_sel_i[k*SW +: SW] & {SW{gnt_q[k]}});
            wbm_adr_o = wbm_adr_o | (wbs_adr_i[k*AW +: AW] & {AW{gnt_q[k]}});
            wbm_dat_o = wbm_dat_o | (wbs_dat_i[k*DW +: DW] & {DW{gnt_q[k]}});
        end
        resp    = wbm_ack_i | wbm_err_i | wbm_rty_i;
        tmo_hit = (TMO != 0) && (tcnt_q == TW'(TMO - 1)) && wbm_stb_o && !resp;
        tmo_o     = tmo_hit;
        wbs_dat_o = wbm_dat_i;
        wbs_ack_o = gnt_q & {NCH{wbm_ack_i}};
        wbs_rty_o = gnt_q & {NCH{wbm_rty_i}};
        wbs_err_o = gnt_q & {NCH{wbm_err_i | tmo_hit}};
    end

    assign gnt_o = gnt_q;

endmodule

// File: tb/tb_wb_mixer_rr.sv
// Bench for wb_mixer_rr: directed scenarios plus randomized channel/slave
// traffic, every cycle compared against an integer-level arbitration model.
module tb_wb_mixer_rr;
    localparam int NCH = 5;
    localparam int DW  = 64;
    localparam int AW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- stimulus ----------------
    logic [NCH-1:0]    cyc, stb, we, cab;
    logic [NCH*SW-1:0] sel;
    logic [NCH*AW-1:0] adr;
    logic [NCH*DW-1:0] dat;
    logic              ack_i, err_i, rty_i;
    logic [DW-1:0]     mdat_i;

    // ---------------- DUT (TMO = 8) outputs ----------------
    logic [DW-1:0]  wbs_dat_o;
    logic [NCH-1:0] wbs_ack_o, wbs_err_o, wbs_rty_o, gnt_o;
    logic           wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o, tmo_o;
    logic [SW-1:0]  wbm_sel_o;
    logic [AW-1:0]  wbm_adr_o;
    logic [DW-1:0]  wbm_dat_o;

    // ---------------- DUT (TMO = 0) outputs ----------------
    logic [DW-1:0]  z_wbs_dat_o;
    logic [NCH-1:0] z_wbs_ack_o, z_wbs_err_o, z_wbs_rty_o, z_gnt_o;
    logic           z_wbm_cyc_o, z_wbm_stb_o, z_wbm_we_o, z_wbm_cab_o, z_tmo_o;
    logic [SW-1:0]  z_wbm_sel_o;
    logic [AW-1:0]  z_wbm_adr_o;
    logic [DW-1:0]  z_wbm_dat_o;

    wb_mixer_rr #(.NCH(NCH), .DW(DW), .AW(AW), .TMO(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_cab_i(cab),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .wbs_rty_o(wbs_rty_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_cab_o(wbm_cab_o), .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o),
        .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(ack_i), .wbm_err_i(err_i), .wbm_rty_i(rty_i), .wbm_dat_i(mdat_i),
        .gnt_o(gnt_o), .tmo_o(tmo_o)
    );

    wb_mixer_rr #(.NCH(NCH), .DW(DW), .AW(AW), .TMO(0)) dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_cab_i(cab),
        .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(dat),
        .wbs_dat_o(z_wbs_dat_o), .wbs_ack_o(z_wbs_ack_o), .wbs_err_o(z_wbs_err_o),
        .wbs_rty_o(z_wbs_rty_o),
        .wbm_cyc_o(z_wbm_cyc_o), .wbm_stb_o(z_wbm_stb_o), .wbm_we_o(z_wbm_we_o),
        .wbm_cab_o(z_wbm_cab_o), .wbm_sel_o(z_wbm_sel_o), .wbm_adr_o(z_wbm_adr_o),
        .wbm_dat_o(z_wbm_dat_o),
        .wbm_ack_i(ack_i), .wbm_err_i(err_i), .wbm_rty_i(rty_i), .wbm_dat_i(mdat_i),
        .gnt_o(z_gnt_o), .tmo_o(z_tmo_o)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, wanted %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // m_own: owning channel or -1; m_last: most recent owner; m_stall:
    // consecutive strobed cycles without any slave response.
    int   m_own, m_last, m_stall;
    logic cur_stb, cur_resp, cur_hit;

    task automatic check_all();
        logic [NCH-1:0] eg;
        logic           ec, es, ew, eb;
        logic [SW-1:0]  esel;
        logic [AW-1:0]  eadr;
        logic [DW-1:0]  edat;
        eg = '0; ec = 1'b0; es = 1'b0; ew = 1'b0; eb = 1'b0;
        esel = '0; eadr = '0; edat = '0;
        if (rst_n && m_own >= 0) begin
            eg   = NCH'(1) << m_own;
            ec   = cyc[m_own];
            es   = stb[m_own];
            ew   = we[m_own];
            eb   = cab[m_own];
            esel = sel[m_own*SW +: SW];
            eadr = adr[m_own*AW +: AW];
            edat = dat[m_own*DW +: DW];
        end
        cur_stb  = es;
        cur_resp = ack_i | err_i | rty_i;
        cur_hit  = es && !cur_resp && (m_stall == TMO - 1);
        check("gnt", gnt_o, eg);
        check("m_cyc", wbm_cyc_o, ec);
        check("m_stb", wbm_stb_o, es);
        check("m_we", wbm_we_o, ew);
        check("m_cab", wbm_cab_o, eb);
        check("m_sel", wbm_sel_o, esel);
        check("m_adr", wbm_adr_o, eadr);
        check("m_dat", wbm_dat_o, edat);
        check("s_dat", wbs_dat_o, mdat_i);
        check("s_ack", wbs_ack_o, eg & {NCH{ack_i}});
        check("s_rty", wbs_rty_o, eg & {NCH{rty_i}});
        check("s_err", wbs_err_o, eg & {NCH{err_i | cur_hit}});
        check("tmo", tmo_o, cur_hit);
        check("z_gnt", z_gnt_o, eg);
        check("z_err", z_wbs_err_o, eg & {NCH{err_i}});
        check("z_tmo", z_tmo_o, 1'b0);
    endtask

    task automatic m_step();
        int nxt;
        if (!rst_n) begin
            m_own = -1; m_last = NCH - 1; m_stall = 0;
            return;
        end
        if (!cur_stb || cur_resp || cur_hit) m_stall = 0;
        else if (m_stall < TMO) m_stall++;
        if (m_own < 0 || !cyc[m_own]) begin
            nxt = -1;
            for (int k = 1; k <= NCH; k++) begin
                if (nxt < 0 && cyc[(m_last + k) % NCH]) nxt = (m_last + k) % NCH;
            end
            m_own = nxt;
            if (nxt >= 0) m_last = nxt;
        end
    endtask

    // ---------------- driver ----------------
    int beats[NCH];
    int raise_pct = 0;
    int max_beats = 4;
    int resp_mode = 1;   // 0 silent slave, 1 ack every strobe, 2 random
    int stall_left = 0;

    task automatic raise(input int k, input int nb);
        beats[k]            = nb;
        cyc[k]              = 1'b1;
        stb[k]              = 1'b1;
        cab[k]              = (nb > 1);
        we[k]               = 1'($urandom_range(0, 1));
        sel[k*SW +: SW]     = SW'($urandom);
        adr[k*AW +: AW]     = $urandom;
        dat[k*DW +: DW]     = {$urandom, $urandom};
    endtask

    task automatic drive();
        logic es;
        int   r;
        for (int k = 0; k < NCH; k++) begin
            if (cyc[k] && beats[k] == 0) begin
                cyc[k] = 1'b0; stb[k] = 1'b0; cab[k] = 1'b0;
            end else if (!cyc[k] && (int'($urandom_range(0, 99)) < raise_pct)) begin
                raise(k, int'($urandom_range(1, max_beats)));
            end else if (cyc[k]) begin
                dat[k*DW +: DW] = {$urandom, $urandom};
            end
        end
        es = 1'b0;
        if (rst_n && m_own >= 0) es = stb[m_own];
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0;
        mdat_i = {$urandom, $urandom};
        if (es) begin
            if (resp_mode == 1) begin
                ack_i = 1'b1;
            end else if (resp_mode == 2) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else if ($urandom_range(0, 15) == 0) begin
                    stall_left = int'($urandom_range(4, 12));
                end else begin
                    r = int'($urandom_range(0, 9));
                    if (r < 5) ack_i = 1'b1;
                    else if (r == 5) err_i = 1'b1;
                    else if (r == 6) rty_i = 1'b1;
                end
            end
        end
    endtask

    // Channel reaction to the response of the cycle just ending.
    task automatic stim_react();
        if (rst_n && m_own >= 0 && cur_stb) begin
            if (cur_hit || err_i || rty_i) beats[m_own] = 0;
            else if (ack_i && beats[m_own] > 0) beats[m_own]--;
        end
    endtask

    // Called just after a negedge with inputs applied.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        stim_react();
        m_step();
        @(negedge clk);
    endtask

    task automatic drain();
        raise_pct = 0;
        resp_mode = 1;
        for (int c = 0; c < 60 && (cyc != '0 || m_own >= 0); c++) begin
            drive();
            tick();
        end
        check("drain", {cyc, gnt_o}, '0);
    endtask

    task automatic wait_for(input logic [NCH-1:0] mask, input int max, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < max && !ok; c++) begin
            drive();
            #1;
            if (gnt_o == mask) ok = 1'b1;
            tick();
        end
    endtask

    // ---------------- main sequence ----------------
    logic [NCH-1:0] exp_q[$];
    logic [NCH-1:0] got_q[$];
    logic [NCH-1:0] last_g;
    logic [AW-1:0]  adr0;
    logic           ok, fired;
    int             n, acks2, drop_c, g1_c, seen2;

    initial begin
        rst_n = 1'b0;
        cyc = '0; stb = '0; we = '0; cab = '0; sel = '0; adr = '0; dat = '0;
        ack_i = 1'b0; err_i = 1'b0; rty_i = 1'b0; mdat_i = '0;
        m_own = -1; m_last = NCH - 1; m_stall = 0;
        cur_stb = 1'b0; cur_resp = 1'b0; cur_hit = 1'b0;
        for (int k = 0; k < NCH; k++) beats[k] = 0;
        @(negedge clk);

        // Reset with every channel requesting, then rotation 0..4,0.
        raise_pct = 100; max_beats = 1; resp_mode = 1;
        for (int k = 0; k < NCH; k++) raise(k, 1);
        adr0 = adr[AW-1:0];
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rst_gnt", gnt_o, '0);
            tick();
        end
        rst_n = 1'b1;
        tick();
        exp_q = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
        got_q.delete();
        last_g = '0;
        for (int c = 0; c < 40 && got_q.size() < 6; c++) begin
            drive();
            #1;
            if (c == 0) begin
                check("first_gnt", gnt_o, 5'b00001);
                check("first_adr", wbm_adr_o, adr0);
            end
            if (gnt_o != '0 && gnt_o != last_g) got_q.push_back(gnt_o);
            last_g = gnt_o;
            tick();
        end
        check("rot_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) check("rot_order", got_q[i], exp_q[i]);
        drain();

        // Channel 2 cab burst of 4 with channel 1 arriving mid-burst.
        resp_mode = 1;
        acks2 = 0; drop_c = -1; g1_c = -1; seen2 = 0;
        raise(2, 4);
        for (int c = 0; c < 20; c++) begin
            drive();
            if (c == 3) raise(1, 1);
            #1;
            if (wbs_ack_o[2]) acks2++;
            if (gnt_o == 5'b00100) seen2 = 1;
            if (seen2 != 0 && !cyc[2] && drop_c < 0) drop_c = c;
            if (gnt_o == 5'b00010 && g1_c < 0) g1_c = c;
            tick();
        end
        check("burst_acks", acks2, 4);
        check("handover", g1_c, drop_c + 1);
        drain();

        // Byte selects and same-cycle read data for channel 3.
        resp_mode = 0;
        raise(3, 1);
        sel[3*SW +: SW] = 8'hF0;
        wait_for(5'b01000, 10, ok);
        check("sel_gnt", ok, 1'b1);
        drive();
        ack_i  = 1'b1;
        mdat_i = 64'h0123_4567_89AB_CDEF;
        #1;
        check("sel_pass", wbm_sel_o, 8'hF0);
        check("rd_data", wbs_dat_o, 64'h0123_4567_89AB_CDEF);
        check("rd_ack", wbs_ack_o, 5'b01000);
        tick();
        drain();

        // Watchdog: silent slave, twice in a row to see the counter restart.
        for (int rep = 0; rep < 2; rep++) begin
            resp_mode = 0;
            raise(0, 1);
            n = 0; fired = 1'b0;
            for (int c = 0; c < 20 && !fired; c++) begin
                drive();
                #1;
                if (wbm_stb_o) n++;
                if (tmo_o) begin
                    fired = 1'b1;
                    check("tmo_err", wbs_err_o, 5'b00001);
                end
                tick();
            end
            check("tmo_fired", fired, 1'b1);
            check("tmo_cycles", n, TMO);
            drain();
        end

        // Channel 4 alone twice, then pointer wrap gives channel 0 priority.
        resp_mode = 1;
        raise(4, 1);
        for (int c = 0; c < 10 && cyc[4]; c++) begin drive(); tick(); end
        raise(4, 1);
        wait_for(5'b10000, 10, ok);
        check("regrant", ok, 1'b1);
        for (int c = 0; c < 10 && cyc[4]; c++) begin drive(); tick(); end
        raise(0, 1);
        raise(4, 1);
        last_g = '0;
        for (int c = 0; c < 10 && last_g == '0; c++) begin
            drive();
            #1;
            last_g = gnt_o;
            tick();
        end
        check("wrap_gnt", last_g, 5'b00001);
        drain();

        // Randomized traffic.
        raise_pct = 25; max_beats = 4; resp_mode = 2;
        for (int c = 0; c < 1500; c++) begin
            drive();
            tick();
        end
        drain();

        // Reset in the middle of a transfer.
        resp_mode = 0;
        raise(1, 3);
        wait_for(5'b00010, 10, ok);
        check("pre_rst_gnt", ok, 1'b1);
        drive();
        ack_i = 1'b1;
        rst_n = 1'b0;
        #1;
        check("rst_cyc", wbm_cyc_o, 1'b0);
        check("rst_ack", wbs_ack_o, '0);
        tick();
        drive();
        tick();
        rst_n = 1'b1;
        drive();
        tick();
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
